// File: rtl/ywb_tile_pack_writer.sv
// rtl/ywb_tile_pack_writer.sv - packs y tiles into memory words and writes them with back-pressure
// Optional YWB_FLUSH_EN adds a flush input that emits a zero-filled partial word.
module ywb_tile_pack_writer #(
  parameter int TILE_SIZE  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DATA_W     = 256,
  parameter int D          = 256,
  parameter int OUT_DEPTH  = 256,
  parameter int OUT_ADDR_W = $clog2(OUT_DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  y_axis_TVALID,
  output logic                                  y_axis_TREADY,
  input  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]  y_axis_TDATA,
  input  logic [OUT_ADDR_W-1:0]                 base_addr,
`ifdef YWB_FLUSH_EN
  input  logic                                  flush,
`endif
  output logic                                  wr_en,
  input  logic                                  wr_ready,
  output logic [OUT_ADDR_W-1:0]                 wr_addr,
  output logic [DATA_W-1:0]                     wr_data,
  output logic                                  vec_done,
  output logic [15:0]                           vec_count
);

  localparam int TILES_PER_WORD = DATA_W / (TILE_SIZE * DATA_WIDTH);
  localparam int WORDS_PER_VEC  = D / (TILE_SIZE * TILES_PER_WORD);
  localparam int SLOT_W = (TILES_PER_WORD > 1) ? $clog2(TILES_PER_WORD) : 1;
  localparam int WC_W   = (WORDS_PER_VEC > 1) ? $clog2(WORDS_PER_VEC) : 1;

  typedef logic [TILES_PER_WORD-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] word_t;

  logic [SLOT_W-1:0]     slot;
  logic [WC_W-1:0]       word_cnt;
  word_t                 pack;
  word_t                 merged;
  word_t                 load_word;
  logic                  busy, accept, last_slot, last_word, fire, load, first_word;
  logic [OUT_ADDR_W-1:0] next_addr;
`ifdef YWB_FLUSH_EN
  logic                  flush_pend;
  logic                  flush_take, flush_load, flush_hold;
`endif

  always_comb begin
    busy      = wr_en && !wr_ready;
    accept    = wr_en && wr_ready;
    last_slot = (slot == SLOT_W'(TILES_PER_WORD - 1));
    last_word = (word_cnt == WC_W'(WORDS_PER_VEC - 1));
    y_axis_TREADY = !(last_slot && busy);
`ifdef YWB_FLUSH_EN
    y_axis_TREADY = y_axis_TREADY && !flush_pend;
`endif
    fire = y_axis_TVALID && y_axis_TREADY;

    merged       = pack;
    merged[slot] = y_axis_TDATA;

    load      = fire && last_slot;
    load_word = merged;
`ifdef YWB_FLUSH_EN
    // Unused slots are already zero because the pack register clears on every load.
    flush_take = flush_pend || (flush && (slot != '0 || fire));
    flush_load = flush_take && !load && !busy;
    flush_hold = flush_take && !load && busy;
    if (flush_load) begin
      load      = 1'b1;
      load_word = fire ? merged : pack;
    end
`endif

    // The word being loaded is word 0 when every earlier write of the vector has been accepted.
    first_word = accept ? last_word : (word_cnt == '0);
    if (first_word)
      next_addr = base_addr;
    else if (wr_addr == OUT_ADDR_W'(OUT_DEPTH - 1))
      next_addr = '0;
    else
      next_addr = wr_addr + OUT_ADDR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      vec_done   <= 1'b0;
      vec_count  <= '0;
      slot       <= '0;
      word_cnt   <= '0;
      pack       <= '0;
`ifdef YWB_FLUSH_EN
      flush_pend <= 1'b0;
`endif
    end else begin
      vec_done <= 1'b0;

      if (load) begin
        wr_en   <= 1'b1;
        wr_data <= load_word;
        wr_addr <= next_addr;
      end else if (accept) begin
        wr_en <= 1'b0;
      end

      if (accept) begin
        if (last_word) begin
          word_cnt  <= '0;
          vec_done  <= 1'b1;
          vec_count <= vec_count + 16'd1;
        end else begin
          word_cnt <= word_cnt + WC_W'(1);
        end
      end

      if (load) begin
        slot <= '0;
        pack <= '0;
      end else if (fire) begin
        slot <= slot + SLOT_W'(1);
        pack <= merged;
      end

`ifdef YWB_FLUSH_EN
      if (load)
        flush_pend <= 1'b0;
      else if (flush_hold)
        flush_pend <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_ywb_tile_pack_writer.sv
// tb/tb_ywb_tile_pack_writer.sv - scoreboard bench for ywb_tile_pack_writer
module tb_ywb_tile_pack_writer;

  localparam int TS = 4, DW = 16, W = 256, DV = 256, DEPTH = 256, AW = 8;
  localparam int TPW = 4, WPV = 16;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   y_valid = 1'b0;
  logic                   y_ready;
  logic [TS-1:0][DW-1:0]  y_data = '0;
  logic [AW-1:0]          base_addr = '0;
  logic                   wr_en;
  logic                   wr_ready = 1'b1;
  logic [AW-1:0]          wr_addr;
  logic [W-1:0]           wr_data;
  logic                   vec_done;
  logic [15:0]            vec_count;
`ifdef YWB_FLUSH_EN
  logic                   flush = 1'b0;
`endif

  always #5 clk = ~clk;

  ywb_tile_pack_writer #(
    .TILE_SIZE(TS), .DATA_WIDTH(DW), .DATA_W(W), .D(DV), .OUT_DEPTH(DEPTH), .OUT_ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .y_axis_TVALID(y_valid), .y_axis_TREADY(y_ready), .y_axis_TDATA(y_data),
    .base_addr(base_addr),
`ifdef YWB_FLUSH_EN
    .flush(flush),
`endif
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .vec_done(vec_done), .vec_count(vec_count)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_t;

  int          tests = 0;
  int          failed = 0;
  wr_t         exp_q[$];
  logic [63:0] tile_buf[$];
  int          m_word = 0;
  int          m_prev_addr = 0;
  int          m_vecs = 0;
  int          vd_seen = 0;
  int          nr_cnt = 0;
  bit          rand_ready = 1'b0;
  bit          held = 1'b0;
  wr_t         hold_v;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: every TPW tiles make a word; word 0 of a vector lands at base_addr, the rest count up mod DEPTH.
  function automatic void model_emit();
    wr_t e;
    e.data = '0;
    for (int t = 0; t < tile_buf.size(); t++) e.data[t*64 +: 64] = tile_buf[t];
    e.addr = (m_word == 0) ? base_addr : AW'((m_prev_addr + 1) % DEPTH);
    m_prev_addr = int'(e.addr);
    exp_q.push_back(e);
    tile_buf.delete();
    m_word++;
    if (m_word == WPV) begin
      m_word = 0;
      m_vecs++;
    end
  endfunction

  function automatic void model_tile(input logic [63:0] d);
    tile_buf.push_back(d);
    if (tile_buf.size() == TPW) model_emit();
  endfunction

  always @(negedge clk) begin
    wr_t e;
    if (y_valid && !y_ready) nr_cnt++;
    if (vec_done) vd_seen++;
    if (held && wr_en) begin
      check("hold_addr", W'(wr_addr), W'(hold_v.addr));
      check("hold_data", wr_data, hold_v.data);
    end
    held = 1'b0;
    if (wr_en && wr_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_write: addr %0h data %0h", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", W'(wr_addr), W'(e.addr));
        check("wr_data", wr_data, e.data);
      end
    end else if (wr_en) begin
      held = 1'b1;
      hold_v.addr = wr_addr;
      hold_v.data = wr_data;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) wr_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic send_tile(input logic [63:0] d);
    int w;
    y_valid = 1'b1;
    y_data  = d;
    w = 0;
    @(negedge clk);
    while (!y_ready && w < 500) begin
      w++;
      @(negedge clk);
    end
    if (w >= 500) begin
      tests++;
      failed++;
      $display("FAIL tready_timeout: ready %0b required 1", y_ready);
    end
    @(posedge clk);
    model_tile(d);
    #1;
    y_valid = 1'b0;
  endtask

  task automatic send_random(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_tile({$urandom, $urandom});
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() > 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("drain_empty", W'(exp_q.size()), W'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] d;

    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", W'(wr_en), W'(0));
    check("rst_wr_addr", W'(wr_addr), W'(0));
    check("rst_wr_data", wr_data, W'(0));
    check("rst_vec_done", W'(vec_done), W'(0));
    check("rst_vec_count", W'(vec_count), W'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_tready", W'(y_ready), W'(1));
    @(posedge clk);
    #1;

    // First word: elements 1..16 at base 0x10, one-cycle write right after the 4th fire.
    base_addr = 8'h10;
    nr_cnt = 0;
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 4; i++) d[i*16 +: 16] = 16'(t*4 + i + 1);
      send_tile(d);
    end
    check("lat_wr_en", W'(wr_en), W'(1));
    check("first_lo", W'(wr_data[15:0]), W'(16'd1));
    check("first_hi", W'(wr_data[255:240]), W'(16'd16));
    check("first_addr", W'(wr_addr), W'(8'h10));
    @(posedge clk);
    #1;
    check("wr_en_one_cycle", W'(wr_en), W'(0));
    send_random(60, 1'b0);
    drain();
    check("v1_no_stall", W'(nr_cnt), W'(0));
    check("v1_vec_count", W'(vec_count), W'(m_vecs));
    check("v1_vec_done", W'(vd_seen), W'(1));

    base_addr = 8'h00;
    nr_cnt = 0;
    send_random(64, 1'b0);
    drain();
    check("v2_no_stall", W'(nr_cnt), W'(0));
    check("v2_vec_count", W'(vec_count), W'(m_vecs));
    check("v2_vec_done", W'(vd_seen), W'(2));

    // Wrapping vector with a 10-cycle write stall during the second word.
    base_addr = 8'hF8;
    nr_cnt = 0;
    send_random(5, 1'b0);
    wr_ready = 1'b0;
    fork
      begin
        repeat (10) @(posedge clk);
        #1;
        wr_ready = 1'b1;
      end
    join_none
    send_random(59, 1'b0);
    drain();
    check("v3_stalled", W'(nr_cnt > 0), W'(1));
    check("v3_vec_count", W'(vec_count), W'(m_vecs));

    for (int v = 0; v < 2; v++) begin
      base_addr = AW'($urandom);
      rand_ready = 1'b1;
      send_random(64, 1'b1);
      rand_ready = 1'b0;
      wr_ready = 1'b1;
      drain();
      check("rand_vec_count", W'(vec_count), W'(m_vecs));
      check("rand_vec_done", W'(vd_seen), W'(m_vecs));
    end

    // Reset after two tiles drops the partial word.
    base_addr = 8'h33;
    send_random(2, 1'b0);
    rst_n = 1'b0;
    tile_buf.delete();
    m_word = 0;
    m_vecs = 0;
    @(negedge clk);
    check("mid_rst_wr_en", W'(wr_en), W'(0));
    check("mid_rst_vec_count", W'(vec_count), W'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    vd_seen = 0;
    base_addr = 8'h20;
    send_random(4, 1'b0);
    drain();
    check("post_rst_vec_count", W'(vec_count), W'(0));
    check("post_rst_vec_done", W'(vd_seen), W'(0));

`ifdef YWB_FLUSH_EN
    send_random(2, 1'b0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    model_emit();
    send_random(4, 1'b0);
    drain();
    check("flush_vec_count", W'(vec_count), W'(m_vecs));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
